i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (responder) for the Nios II on-chip I2C master's open-drain pins (sda_in/scl_in in, sda_oe/scl_oe out; oe=1 pulls low).
- Exposes an 8-bit register bank at a fixed 7-bit address, with a register pointer that auto-increments.
- Fabric logic reads and writes the same bank through a local port and gets a strobe on every I2C write.
- Used to bring up and test firmware I2C transactions without external GreenPAK silicon.

Parameters:
- I2C_ADDR, 7'h50, 7-bit target address matched in the address byte.
- NUM_REGS, 16, register count; power of two, 2..256.
- FILTER_LEN, 3, glitch-filter depth in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic is on the rising edge; must be at least 16x the SCL rate.
- reset  in  1  synchronous, active-high reset.
- scl_in  in  1  SCL pin level, asynchronous.
- sda_in  in  1  SDA pin level, asynchronous.
- scl_oe  out  1  SCL pull-low; tied to 0 (no clock stretching).
- sda_oe  out  1  SDA pull-low (ACK or read data 0).
- usr_addr  in  $clog2(NUM_REGS)  local-port register index.
- usr_we  in  1  local write enable.
- usr_wdata  in  8  local write data.
- usr_rdata  out  8  regs[usr_addr], registered, 1-cycle latency.
- wr_pulse  out  1  one-cycle pulse per byte written over I2C.
- wr_addr  out  $clog2(NUM_REGS)  index of the byte written; valid with wr_pulse.
- wr_data  out  8  value of the byte written; valid with wr_pulse.
- busy  out  1  high from a START with matching address until STOP or NACK-release.

Behaviour:
- Input path: 2-FF synchronizer on scl_in and sda_in, then the optional filter, then the edge detector. SCL rise/fall and SDA rise/fall are each a 1-cycle event.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are legal in any state and override bit processing in the same cycle.
- Data bits are sampled on the SCL rise event. sda_oe changes only in the cycle after an SCL fall event. Total latency from SCL pin fall to sda_oe ≤ 4 cycles, plus FILTER_LEN when filtered.
- State machine:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits MSB first. On match go to ADDR_ACK; on mismatch go to WAIT_STOP.
  - ADDR_ACK: drive ACK (sda_oe=1) for one SCL low-high-low. After the ACK's SCL fall: if R/W=0 go to REG; if R/W=1 load shift=regs[ptr], drive its bit 7, and go to RDATA.
  - REG: shift 8 bits, then ptr <= byte mod NUM_REGS, go to REG_ACK (ACK), then WDATA.
  - WDATA: shift 8 bits, then regs[ptr] <= byte, pulse wr_pulse/wr_addr/wr_data, go to WDATA_ACK (ACK). After the ACK, ptr <= (ptr+1) mod NUM_REGS and return to WDATA.
  - RDATA: drive 8 bits; sda_oe = ~bit. After the 8th SCL fall release SDA; go to MACK.
  - MACK: sample SDA on SCL rise. If 0 (ACK): ptr+1 wrapped, load the next byte, go to RDATA. If 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; on START go to ADDR, on STOP go to IDLE.
- Repeated START from any state clears the bit counter, releases SDA and goes to ADDR. ptr is kept, so a write-pointer/RS/read sequence works.
- STOP from any state releases SDA and goes to IDLE. A partial byte is discarded and regs are unchanged.
- General call (address 0x00) is NACKed, not matched.
- Simultaneous usr_we and I2C write to the same index in one cycle: the I2C write wins and the usr write is dropped. Different indices: both take effect.
- Reset (including mid-transfer): state=IDLE; sda_oe=0, scl_oe=0; ptr=0; all regs=0x00; wr_pulse=0, wr_addr=0, wr_data=0; busy=0; usr_rdata=0; synchronizers preset to 1 (idle bus).

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: each synchronized line passes a FILTER_LEN-cycle majority/stable filter. The output changes only after FILTER_LEN consecutive equal samples, so pulses shorter than FILTER_LEN cycles are suppressed.
- Undefined: the synchronizer output feeds edge detection directly, FILTER_LEN is ignored, and latency is reduced by FILTER_LEN.

Test Plan:
- Write: START, 0xA0, 0x03, 0x11, 0x22, STOP → three ACKs then ACK; regs[3]=0x11, regs[4]=0x22. wr_pulse twice: (3,0x11) then (4,0x22). busy returns to 0 after STOP.
- Random read: START, 0xA0, 0x03, RS, 0xA1, read 2 bytes (ACK then NACK), STOP → bus bytes 0x11, 0x22; sda_oe=0 after NACK.
- Wrap: write ptr 0x0F with data 0xAA, 0xBB → regs[15]=0xAA, regs[0]=0xBB. Pointer byte 0x13 with NUM_REGS=16 → ptr=3.
- Address mismatch: START, 0xA2, 0x55, STOP → no ACK (sda_oe stays 0); regs unchanged; busy stays 0.
- Collision and reset: usr_we to index 4 (0x77) in the same cycle as the I2C write of 0x22 to index 4 → regs[4]=0x22. Assert reset during the 5th data bit → sda_oe=0 next cycle, all regs read back 0x00.
- Filter (macro defined, FILTER_LEN=3): 2-cycle SDA low glitch while SCL high → no START detected, state stays IDLE.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing an auto-incrementing 8-bit register bank plus a local fabric port.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stable filter on SCL/SDA.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR   = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        scl_oe,
  output logic                        sda_oe,
  input  logic [$clog2(NUM_REGS)-1:0] usr_addr,
  input  logic                        usr_we,
  input  logic [7:0]                  usr_wdata,
  output logic [7:0]                  usr_rdata,
  output logic                        wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);
  localparam int AW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_AACK, S_REG, S_RACK,
    S_WDATA, S_WACK, S_RDATA, S_MACK, S_WAIT
  } state_t;

  logic r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic w_scl, w_sda, r_scl_d, r_sda_d;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_byte_done, w_match, w_i2c_we;
  state_t r_state, w_next;
  logic [3:0]    r_cnt;
  logic [7:0]    r_shift;
  logic          r_rw;
  logic [AW-1:0] r_ptr, w_ptr_inc;
  logic [7:0]    r_regs [NUM_REGS];
  logic [7:0]    w_rd_cur, w_rd_nxt;
  logic          r_sda_oe, r_wr_pulse;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data, r_usr_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      r_sda_s2 <= r_sda_s1;
      r_scl_d  <= w_scl;
      r_sda_d  <= w_sda;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] r_scl_fc, r_sda_fc;
  logic          r_scl_f, r_sda_f;

  // A line only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_f  <= 1'b1;
      r_sda_f  <= 1'b1;
      r_scl_fc <= '0;
      r_sda_fc <= '0;
    end else begin
      if (r_scl_s2 == r_scl_f) begin
        r_scl_fc <= '0;
      end else if (r_scl_fc == CW'(FILTER_LEN - 1)) begin
        r_scl_f  <= r_scl_s2;
        r_scl_fc <= '0;
      end else begin
        r_scl_fc <= r_scl_fc + 1'b1;
      end
      if (r_sda_s2 == r_sda_f) begin
        r_sda_fc <= '0;
      end else if (r_sda_fc == CW'(FILTER_LEN - 1)) begin
        r_sda_f  <= r_sda_s2;
        r_sda_fc <= '0;
      end else begin
        r_sda_fc <= r_sda_fc + 1'b1;
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  assign w_scl = r_scl_s2;
  assign w_sda = r_sda_s2;
`endif

  assign w_scl_rise  = w_scl & ~r_scl_d;
  assign w_scl_fall  = ~w_scl & r_scl_d;
  assign w_start     = r_sda_d & ~w_sda & w_scl;
  assign w_stop      = ~r_sda_d & w_sda & w_scl;
  assign w_byte_done = w_scl_fall & (r_cnt == 4'd8);
  assign w_match     = (r_shift[7:1] == I2C_ADDR) && (r_shift[7:1] != 7'd0);
  assign w_ptr_inc   = r_ptr + 1'b1;
  assign w_rd_cur    = r_regs[r_ptr];
  assign w_rd_nxt    = r_regs[w_ptr_inc];
  assign w_i2c_we    = (r_state == S_WDATA) & w_byte_done & ~w_start & ~w_stop;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = S_ADDR;
    end else if (w_stop) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_ADDR:  if (w_byte_done) w_next = w_match ? S_AACK : S_WAIT;
        S_AACK:  if (w_scl_fall) w_next = r_rw ? S_RDATA : S_REG;
        S_REG:   if (w_byte_done) w_next = S_RACK;
        S_RACK:  if (w_scl_fall) w_next = S_WDATA;
        S_WDATA: if (w_byte_done) w_next = S_WACK;
        S_WACK:  if (w_scl_fall) w_next = S_WDATA;
        S_RDATA: if (w_scl_fall && r_cnt == 4'd7) w_next = S_MACK;
        S_MACK: begin
          if (w_scl_rise && w_sda) w_next = S_WAIT;
          else if (w_scl_fall)     w_next = S_RDATA;
        end
        default: w_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_wr_pulse <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_pulse <= 1'b0;
      if (w_start || w_stop) begin
        r_cnt    <= '0;
        r_sda_oe <= 1'b0;
      end else begin
        unique case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_scl_rise && r_cnt != 4'd8) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end
            if (w_byte_done) begin
              r_cnt    <= '0;
              r_sda_oe <= 1'b1;
              if (r_state == S_ADDR) begin
                r_rw     <= r_shift[0];
                r_sda_oe <= w_match;
              end
              if (r_state == S_REG) r_ptr <= r_shift[AW-1:0];
              if (r_state == S_WDATA) begin
                r_wr_pulse <= 1'b1;
                r_wr_addr  <= r_ptr;
                r_wr_data  <= r_shift;
              end
            end
          end
          S_AACK: if (w_scl_fall) begin
            r_cnt    <= '0;
            r_shift  <= w_rd_cur;
            r_sda_oe <= r_rw & ~w_rd_cur[7];
          end
          S_RACK: if (w_scl_fall) r_sda_oe <= 1'b0;
          S_WACK: if (w_scl_fall) begin
            r_sda_oe <= 1'b0;
            r_ptr    <= w_ptr_inc;
          end
          S_RDATA: if (w_scl_fall) begin
            if (r_cnt == 4'd7) begin
              r_cnt    <= '0;
              r_sda_oe <= 1'b0;
            end else begin
              r_cnt    <= r_cnt + 4'd1;
              r_shift  <= {r_shift[6:0], 1'b0};
              r_sda_oe <= ~r_shift[6];
            end
          end
          // Only an ACKed byte stays here until the fall; NACK left on the rise.
          S_MACK: if (w_scl_fall) begin
            r_ptr    <= w_ptr_inc;
            r_shift  <= w_rd_nxt;
            r_sda_oe <= ~w_rd_nxt[7];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_usr_rdata <= '0;
    end else begin
      r_usr_rdata <= r_regs[usr_addr];
      if (usr_we && !(w_i2c_we && usr_addr == r_ptr))
        r_regs[usr_addr] <= usr_wdata;
      if (w_i2c_we) r_regs[r_ptr] <= r_shift;
    end
  end

  assign scl_oe    = 1'b0;
  assign sda_oe    = r_sda_oe;
  assign usr_rdata = r_usr_rdata;
  assign wr_pulse  = r_wr_pulse;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = !(r_state inside {S_IDLE, S_ADDR, S_WAIT});
endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged open-drain master, vector table,
// hand sequences and a randomized run against an array model of the bank.
module tb_i2c_target_regs;
  localparam int PH = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_oe, sda_oe, wr_pulse, busy;
  logic       usr_we = 1'b0;
  logic [3:0] usr_addr = '0, wr_addr;
  logic [7:0] usr_wdata = '0, usr_rdata, wr_data;
  logic       sda_bus, scl_bus;

  assign sda_bus = sda_m & ~sda_oe;
  assign scl_bus = scl_m & ~scl_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk(clk), .reset(reset),
    .scl_in(scl_bus), .sda_in(sda_bus),
    .scl_oe(scl_oe), .sda_oe(sda_oe),
    .usr_addr(usr_addr), .usr_we(usr_we),
    .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int oe_hi = 0;
  logic [11:0] wq[$];
  logic [11:0] eq[$];
  int wq_rd = 0;

  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_hi++;
    if (wr_pulse === 1'b1) wq.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; cyc(PH);
    scl_m = 1'b1; cyc(PH);
    sda_m = 1'b0; cyc(PH);
    scl_m = 1'b0; cyc(2);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; cyc(PH);
    scl_m = 1'b1; cyc(PH);
    sda_m = 1'b1; cyc(PH);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    cyc(PH);
    scl_m = 1'b1; cyc(PH);
    scl_m = 1'b0; cyc(2);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; cyc(PH);
    scl_m = 1'b1; cyc(PH);
    b = sda_bus;
    scl_m = 1'b0; cyc(2);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    get_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(output logic [7:0] v, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(~mack);
  endtask

  task automatic usr_read(input int idx, output logic [7:0] v);
    usr_addr = 4'(idx);
    cyc(1);
    v = usr_rdata;
  endtask

  task automatic chk_wq;
    int n;
    n = wq.size() - wq_rd;
    chk("wr_pulse_count", n, eq.size());
    for (int i = 0; i < n && i < eq.size(); i++)
      chk("wr_pulse_addr_data", wq[wq_rd+i], eq[i]);
    wq_rd = wq.size();
    eq.delete();
  endtask

  typedef struct {
    logic [7:0] adr, ptr, d0, d1;
    logic       ack;
    int         i0;
    logic [7:0] e0;
    int         i1;
    logic [7:0] e1;
  } vec_t;

  vec_t vt[5];

  initial begin
    #900_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack, b, hit;
    logic [7:0] v, d;
    logic [3:0] nib;
    logic [7:0] m[16];
    int mptr, p, n, op, idx, base;

    vt[0] = '{8'hA0, 8'h03, 8'h11, 8'h22, 1'b1, 3,  8'h11, 4, 8'h22};
    vt[1] = '{8'hA0, 8'h0F, 8'hAA, 8'hBB, 1'b1, 15, 8'hAA, 0, 8'hBB};
    vt[2] = '{8'hA2, 8'h55, 8'h66, 8'h77, 1'b0, 5,  8'h00, 3, 8'h11};
    vt[3] = '{8'hA0, 8'h18, 8'h5C, 8'h6D, 1'b1, 8,  8'h5C, 9, 8'h6D};
    vt[4] = '{8'h00, 8'h01, 8'h02, 8'h03, 1'b0, 1,  8'h00, 2, 8'h00};

    cyc(3);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_usr_rdata", usr_rdata, 0);
    reset = 1'b0;
    cyc(3);

    for (int t = 0; t < 5; t++) begin
      base = oe_hi;
      i2c_start;
      wr_byte(vt[t].adr, ack);
      chk("vec_addr_ack", ack, vt[t].ack);
      chk("vec_busy", busy, vt[t].ack);
      wr_byte(vt[t].ptr, ack);
      chk("vec_ptr_ack", ack, vt[t].ack);
      wr_byte(vt[t].d0, ack);
      chk("vec_d0_ack", ack, vt[t].ack);
      wr_byte(vt[t].d1, ack);
      chk("vec_d1_ack", ack, vt[t].ack);
      if (vt[t].ack) begin
        eq.push_back({4'(vt[t].ptr), vt[t].d0});
        eq.push_back({4'(vt[t].ptr + 8'd1), vt[t].d1});
      end
      i2c_stop;
      chk("vec_busy_after_stop", busy, 0);
      if (!vt[t].ack) chk("vec_no_sda_drive", oe_hi - base, 0);
      chk_wq();
      usr_read(vt[t].i0, v);
      chk("vec_reg_a", v, vt[t].e0);
      usr_read(vt[t].i1, v);
      chk("vec_reg_b", v, vt[t].e1);
    end

    // usr port hammers index 4 while the I2C write of 0x22 lands there
    i2c_start;
    wr_byte(8'hA0, ack);
    wr_byte(8'h04, ack);
    fork
      wr_byte(8'h22, ack);
      begin
        hit = 1'b0;
        usr_addr = 4'd4; usr_wdata = 8'h77; usr_we = 1'b1;
        for (int k = 0; k < 400 && !hit; k++) begin
          @(negedge clk);
          if (wr_pulse) hit = 1'b1;
        end
        usr_we = 1'b0;
        chk("coll_pulse_seen", hit, 1);
      end
    join
    chk("coll_ack", ack, 1);
    i2c_stop;
    eq.push_back({4'd4, 8'h22});
    chk_wq();
    usr_read(4, v);
    chk("coll_i2c_wins", v, 8'h22);

    i2c_start;
    wr_byte(8'hA0, ack); chk("rd_addr_w_ack", ack, 1);
    wr_byte(8'h03, ack); chk("rd_ptr_ack", ack, 1);
    i2c_start;
    wr_byte(8'hA1, ack); chk("rd_addr_r_ack", ack, 1);
    rd_byte(v, 1'b1);    chk("rd_byte0", v, 8'h11);
    rd_byte(v, 1'b0);    chk("rd_byte1", v, 8'h22);
    cyc(4);
    chk("rd_sda_after_nack", sda_oe, 0);
    chk("rd_busy_after_nack", busy, 0);
    i2c_stop;
    chk_wq();

    // reset while the target is driving a 0 in the 5th bit of 0x11
    i2c_start;
    wr_byte(8'hA0, ack);
    wr_byte(8'h03, ack);
    i2c_start;
    wr_byte(8'hA1, ack);
    for (int i = 3; i >= 0; i--) begin
      get_bit(b);
      nib[i] = b;
    end
    chk("rst_rd_nibble", nib, 4'h1);
    sda_m = 1'b1; cyc(PH);
    scl_m = 1'b1; cyc(2);
    chk("rst_pre_sda_oe", sda_oe, 1);
    reset = 1'b1;
    cyc(1);
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_wr_addr", wr_addr, 0);
    chk("rst_mid_wr_data", wr_data, 0);
    cyc(2);
    reset = 1'b0;
    cyc(4);
    for (int i = 0; i < 16; i++) begin
      usr_read(i, v);
      chk("rst_regs_zero", v, 0);
    end
    wq_rd = wq.size();

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    sda_m = 1'b0; cyc(2);
    sda_m = 1'b1; cyc(6);
    chk("glitch_busy", busy, 0);
    scl_m = 1'b0; cyc(2);
    wr_byte(8'hA0, ack);
    chk("glitch_no_start", ack, 0);
    i2c_stop;
`endif

    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    mptr = 0;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      if (op == 0) begin
        idx = $urandom_range(0, 15);
        d = 8'($urandom);
        usr_addr = 4'(idx); usr_wdata = d; usr_we = 1'b1;
        cyc(1);
        usr_we = 1'b0;
        m[idx] = d;
      end else if (op == 1) begin
        i2c_start;
        wr_byte(8'hA0, ack); chk("rnd_wr_addr_ack", ack, 1);
        p = $urandom_range(0, 255);
        wr_byte(8'(p), ack); chk("rnd_wr_ptr_ack", ack, 1);
        mptr = p % 16;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          d = 8'($urandom);
          wr_byte(d, ack); chk("rnd_wr_data_ack", ack, 1);
          m[mptr] = d;
          eq.push_back({4'(mptr), d});
          mptr = (mptr + 1) % 16;
        end
        i2c_stop;
        chk_wq();
      end else if (op == 2) begin
        if ($urandom_range(0, 1) == 1) begin
          i2c_start;
          wr_byte(8'hA0, ack); chk("rnd_rd_addr_w_ack", ack, 1);
          p = $urandom_range(0, 255);
          wr_byte(8'(p), ack); chk("rnd_rd_ptr_ack", ack, 1);
          mptr = p % 16;
        end
        i2c_start;
        wr_byte(8'hA1, ack); chk("rnd_rd_addr_r_ack", ack, 1);
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          rd_byte(v, j != n - 1);
          chk("rnd_rd_data", v, m[mptr]);
          if (j != n - 1) mptr = (mptr + 1) % 16;
        end
        i2c_stop;
        chk("rnd_rd_busy", busy, 0);
      end else begin
        idx = $urandom_range(0, 15);
        usr_read(idx, v);
        chk("rnd_usr_read", v, m[idx]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      usr_read(i, v);
      chk("final_bank", v, m[i]);
    end
    chk_wq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
